uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 115200, line rate in bits per second.
REQ-003 Parameter NREQ, default 4, number of requesters, legal range 2..8.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetn  input  1  reset, synchronous and active-low.
REQ-006 req_valid  input  NREQ  per-requester byte valid.
REQ-007 req_data  input  8*NREQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_last  input  NREQ  per-requester end-of-packet marker, qualified by req_valid.
REQ-009 req_ready  output  NREQ  per-requester accept; a transfer occurs when valid and ready are both high.
REQ-010 uart_tx  output  1  serial line, idle high.
REQ-011 busy  output  1  high while a frame is on the line or a packet lock is held.
REQ-012 grant_id  output  clog2(NREQ)  index of the most recently accepted requester.

Function
REQ-013 DIV = CLK_HZ/BAUDRATE, integer truncation (104 at defaults); DIV < 2 shall trigger a simulation-time fatal error.
REQ-014 Serializer FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: uart_tx=1; at most one req_ready bit high, combinationally selected by the arbiter; a transfer latches the byte and moves to START on the next edge.
REQ-016 START: uart_tx=0 for DIV cycles, then DATA.
REQ-017 DATA: 8 bits LSB first, each held DIV cycles; the 3-bit bit counter wraps 7->0, then STOP.
REQ-018 STOP: uart_tx=1 for DIV cycles, then IDLE.
REQ-019 Frame length shall be 10*DIV cycles; the minimum start-to-start spacing of back-to-back frames shall be 10*DIV+1 cycles (one IDLE cycle).
REQ-020 req_ready shall be all-zero in every state except IDLE.
REQ-021 Unlocked arbitration: round-robin; the search starts at index ptr and wraps at NREQ-1->0; the first requester with valid high wins.
REQ-022 On a transfer with last=0, the arbiter shall lock to that requester; while locked, only that requester may see ready, and others wait indefinitely.
REQ-023 On a transfer with last=1, the lock shall be released and ptr set to (granted+1) mod NREQ.
REQ-024 A locked requester that drops valid shall keep the lock; there is no timeout, and the line stays idle high.
REQ-025 In unlocked IDLE with no valid inputs, the state and ptr shall be unchanged.
REQ-026 grant_id shall update on the same edge as the transfer.
REQ-027 busy = (state != IDLE) OR lock.
REQ-028 Changes to req_data or req_valid after acceptance shall not affect the frame in flight.

Reset
REQ-029 While resetn is low at a rising edge: state=IDLE, uart_tx=1, lock=0, ptr=0, grant_id=0, bit and baud counters=0, and req_ready forced to 0.
REQ-030 Reset mid-frame shall abort the frame, with uart_tx=1 from the next edge; the aborted byte is not retransmitted.
REQ-031 On the first cycle after reset release, requester 0 shall have highest priority.

Structure
REQ-032 Shared definitions file uart_defs: FSM state encodings and the DIV computation, reused by other UART blocks.
REQ-033 One sub-module, uart_tx_serializer (FSM plus baud and bit counters, byte in with valid/ready, serial out); the arbiter, lock and ptr logic stay in the top level.

Verification
REQ-034 Single byte 0x55 from requester 2 at defaults -> uart_tx low for 104 cycles, then bits 1,0,1,0,1,0,1,0 for 104 cycles each, then high; bench monitor decodes 0x55; grant_id=2.
REQ-035 All four requesters valid with last=1 and data 0x41..0x44 -> output order 0x41,0x42,0x43,0x44; fifth round begins at requester 0.
REQ-036 Requester 1 sends packet 0xA0,0xA1,0xA2 with last on the third byte while requester 0 is continuously valid with 0xB0 -> line order A0,A1,A2,B0.
REQ-037 Locked requester 3 drops valid for 500 cycles -> uart_tx stays 1, busy stays 1, requester 0 is never ready; the next 3 byte follows on resume.
REQ-038 resetn pulsed low for 1 cycle during DATA bit 4 -> uart_tx=1 on the next edge, all outputs at reset values, lock cleared; a new byte afterwards transmits correctly.
REQ-039 Back-to-back bytes from one requester -> start edges exactly 1041 cycles apart at defaults.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: definitions shared by the UART blocks.
//   uart_state_e : serializer FSM state encoding (IDLE, START, DATA, STOP)
//   uart_div()   : clock cycles per bit, CLK_HZ/BAUDRATE truncated
package uart_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 transmitter, one byte per frame, LSB first.
//   clk, resetn : clock, synchronous active-low reset
//   in_valid    : byte accepted this cycle (qualified by in_ready upstream)
//   in_data     : byte to send, latched on acceptance
//   in_ready    : high in IDLE only
//   tx          : registered serial line, idle high
//   busy        : a frame is on the line
module uart_tx_serializer
  import uart_defs::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign baud_end = (baud_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (in_valid) begin
          data_d  = in_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;   // wraps 7->0 as the frame leaves DATA
          if (bit_q == 3'd7) state_d = ST_STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level is computed from the next state so tx is a clean flop output
  // that changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = data_d[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: NREQ byte streams share one UART transmitter.
// Round-robin between requesters; a byte with last=0 locks the arbiter to
// its requester until that requester sends a byte with last=1.
//   clk, resetn : clock, synchronous active-low reset
//   req_valid   : per-requester byte valid
//   req_data    : per-requester byte, requester i at [8i+7:8i]
//   req_last    : per-requester end-of-packet, qualified by req_valid
//   req_ready   : per-requester accept (at most one high, IDLE only)
//   uart_tx     : serial line, idle high
//   busy        : frame on the line or packet lock held
//   grant_id    : most recently accepted requester
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int CLK_HZ   = 12_000_000,
  parameter int BAUDRATE = 115200,
  parameter int NREQ     = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic                    uart_tx,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int DIV = uart_div(CLK_HZ, BAUDRATE);
  localparam int IDW = $clog2(NREQ);

  if (DIV < 2) begin : g_bad_div
    $fatal(1, "uart_tx_arbiter: CLK_HZ/BAUDRATE must be at least 2");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $fatal(1, "uart_tx_arbiter: NREQ must be in 2..8");
  end

  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant_q, grant_d;

  logic           ser_ready, ser_busy, xfer, found, xfer_last;
  logic [IDW-1:0] win, sel;
  logic [7:0]     xfer_data;

  // Round-robin search starting at ptr, wrapping NREQ-1 -> 0.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // While locked, the lock holder owns ready even with valid low, so nobody
  // else can slip in between bytes of its packet.
  always_comb begin
    req_ready = '0;
    sel       = lock_q ? lock_id_q : win;
    if (resetn && ser_ready) begin
      if (lock_q)     req_ready[lock_id_q] = 1'b1;
      else if (found) req_ready[win]       = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == sel) begin
        xfer_data = req_data[8*i +: 8];
        xfer_last = req_last[i];
      end
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    if (xfer) begin
      grant_d = sel;
      if (xfer_last) begin
        lock_d = 1'b0;
        ptr_d  = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
      end else begin
        lock_d    = 1'b1;
        lock_id_d = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
    end
  end

  uart_tx_serializer #(.DIV(DIV)) u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (xfer),
    .in_data  (xfer_data),
    .in_ready (ser_ready),
    .tx       (uart_tx),
    .busy     (ser_busy)
  );

  assign busy     = ser_busy | lock_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DIV  = 104;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0] req_last = '0;
  logic [NREQ-1:0] req_ready;
  logic            uart_tx, busy;
  logic [1:0]      grant_id;

  uart_tx_arbiter dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .uart_tx(uart_tx),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-requester byte queues {last,data}; a driver presents the head.
  logic [8:0]      txq [NREQ][$];
  logic [NREQ-1:0] hold = '0;

  task automatic push(input int r, input logic [7:0] d, input logic l);
    txq[r].push_back({l, d});
  endtask

  initial begin
    logic [NREQ-1:0] m;
    forever begin
      @(negedge clk);
      m = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (m[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        if (txq[i].size() > 0 && !hold[i]) begin
          req_valid[i]        = 1'b1;
          req_data[8*i +: 8]  = txq[i][0][7:0];
          req_last[i]         = txq[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Line monitor: decodes 8N1 by sampling mid-bit.
  logic [7:0] rxq[$];
  int         rxst[$];
  initial begin
    logic [7:0] d;
    int st;
    forever begin
      @(negedge clk);
      if (resetn && uart_tx === 1'b0) begin
        st = cyc;
        repeat (DIV/2) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          d[b] = uart_tx;
        end
        repeat (DIV) @(negedge clk);
        rxq.push_back(d);
        rxst.push_back(st);
      end
    end
  end

  function automatic logic [7:0] rx_at(input int i);
    if (i < rxq.size()) return rxq[i];
    return 8'hxx;
  endfunction

  task automatic flush();
    rxq.delete();
    rxst.delete();
  endtask

  task automatic wait_rx(input int n, input string tag);
    int t = 0;
    while (rxq.size() < n && t < 20000) begin @(negedge clk); t++; end
    chk(tag, 32'(rxq.size() >= n), 1);
  endtask

  task automatic wait_q(input int r, input string tag);
    int t = 0;
    while (txq[r].size() > 0 && t < 20000) begin @(negedge clk); t++; end
    chk(tag, 32'(txq[r].size() == 0), 1);
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (req_ready == '0 && t < 3000) begin @(negedge clk); t++; end
    chk(tag, 32'(req_ready != '0), 1);
  endtask

  task automatic wait_low(input string tag);
    int t = 0;
    while (uart_tx !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
    chk(tag, 32'(uart_tx), 0);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad_tx, bad_busy, bad_rdy;

    // Reset state, with all four requesters already valid.
    for (int i = 0; i < NREQ; i++) push(i, 8'h41 + 8'(i), 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(uart_tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_gid", 32'(grant_id), 0);
    @(posedge clk); #2 resetn = 1'b1;
    @(negedge clk);
    chk("rel_prio", 32'(req_ready), 32'b0001);

    // Round robin, one byte each, last=1.
    wait_rx(4, "rr_rx");
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(rx_at(i)), 32'h41 + i);
    flush();
    for (int i = 0; i < NREQ; i++) push(i, 8'h61 + 8'(i), 1'b1);
    wait_ready("rr5_rdy");
    chk("rr5_first", 32'(req_ready), 32'b0001);
    wait_rx(4, "rr5_rx");
    for (int i = 0; i < 4; i++) chk("rr5_order", 32'(rx_at(i)), 32'h61 + i);
    flush();

    // Single 0x55 from requester 2; then a byte from requester 0 must wait.
    push(2, 8'h55, 1'b1);
    wait_low("s55_low");
    n = 0;
    while (uart_tx === 1'b0 && n < 2000) begin n++; @(negedge clk); end
    chk("start_len", n, DIV);
    chk("gid2", 32'(grant_id), 2);
    chk("busy_mid", 32'(busy), 1);
    push(0, 8'h5A, 1'b1);
    repeat (20) @(negedge clk);
    chk("ready_mid", 32'(req_ready), 0);
    wait_rx(2, "s55_rx");
    chk("s55_byte", 32'(rx_at(0)), 32'h55);
    chk("s5a_byte", 32'(rx_at(1)), 32'h5A);
    flush();

    // Packet from requester 1 is not interrupted by requester 0.
    push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b1);
    push(0, 8'hB0, 1'b1);
    wait_rx(4, "pkt_rx");
    chk("pkt0", 32'(rx_at(0)), 32'hA0);
    chk("pkt1", 32'(rx_at(1)), 32'hA1);
    chk("pkt2", 32'(rx_at(2)), 32'hA2);
    chk("pkt3", 32'(rx_at(3)), 32'hB0);
    flush();

    // Locked requester 3 stalls for 500 cycles.
    push(3, 8'hC0, 1'b0);
    wait_q(3, "lock_acc");
    hold[3] = 1'b1;
    push(3, 8'hC1, 1'b1);
    push(0, 8'hD0, 1'b1);
    wait_rx(1, "lock_rx0");
    repeat (60) @(negedge clk);
    bad_tx = 0; bad_busy = 0; bad_rdy = 0;
    repeat (500) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad_tx++;
      if (busy !== 1'b1) bad_busy++;
      if (req_ready[0] !== 1'b0) bad_rdy++;
    end
    chk("stall_tx", bad_tx, 0);
    chk("stall_busy", bad_busy, 0);
    chk("stall_rdy0", bad_rdy, 0);
    hold[3] = 1'b0;
    wait_rx(3, "lock_rx");
    chk("lock0", 32'(rx_at(0)), 32'hC0);
    chk("lock1", 32'(rx_at(1)), 32'hC1);
    chk("lock2", 32'(rx_at(2)), 32'hD0);
    flush();

    // Back-to-back bytes from one requester.
    push(2, 8'h12, 1'b1); push(2, 8'h34, 1'b1);
    wait_rx(2, "b2b_rx");
    chk("b2b0", 32'(rx_at(0)), 32'h12);
    chk("b2b1", 32'(rx_at(1)), 32'h34);
    chk("b2b_gap", (rxst.size() > 1) ? rxst[1] - rxst[0] : 0, 10*DIV + 1);
    flush();

    // Reset pulse during data bit 4 of a locking byte (bit 4 of 0x0F is 0).
    push(1, 8'h0F, 1'b0);
    wait_low("abort_low");
    repeat (DIV + 4*DIV + 50) @(negedge clk);
    chk("bit4_low", 32'(uart_tx), 0);
    @(posedge clk); #2 resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_tx", 32'(uart_tx), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_gid", 32'(grant_id), 0);
    chk("abort_rdy", 32'(req_ready), 0);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("unlock_busy", 32'(busy), 0);
    repeat (700) @(negedge clk);
    flush();
    push(0, 8'h5A, 1'b1);
    wait_ready("post_rdy_wait");
    chk("post_rdy", 32'(req_ready), 32'b0001);
    wait_rx(1, "post_rx");
    chk("post_byte", 32'(rx_at(0)), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
